// File: rtl/d_e_reg.sv
// D->E pipeline register: captures one decoded instruction and hands it to E; bubbles on stall, flushes to the handler PC on req.
// Latency 1 cycle; no backpressure of its own, since the hazard unit's stall/req choose bubble or flush instead of holding.
module d_e_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        stall,
    input  logic [31:0] D_pc,
    input  logic [31:0] D_instr,
    input  logic [31:0] D_rs_data,
    input  logic [31:0] D_rt_data,
    input  logic [31:0] D_ext_imm,
    input  logic [4:0]  D_exc_code,
    input  logic        D_bd,
    output logic [31:0] E_pc,
    output logic [31:0] E_instr,
    output logic [31:0] E_rs_data,
    output logic [31:0] E_rt_data,
    output logic [31:0] E_ext_imm,
    output logic [4:0]  E_exc_code,
    output logic        E_bd,
    output logic        E_valid
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            E_pc       <= RESET_PC;
            E_instr    <= '0;
            E_rs_data  <= '0;
            E_rt_data  <= '0;
            E_ext_imm  <= '0;
            E_exc_code <= '0;
            E_bd       <= 1'b0;
            E_valid    <= 1'b0;
        end else if (req) begin
            E_pc       <= HANDLER_PC;
            E_instr    <= '0;
            E_rs_data  <= '0;
            E_rt_data  <= '0;
            E_ext_imm  <= '0;
            E_exc_code <= '0;
            E_bd       <= 1'b0;
            E_valid    <= 1'b0;
        end else if (stall) begin
            // Bubble keeps the stalled instruction's PC/BD so an interrupt taken here gets the right EPC.
            E_pc       <= D_pc;
            E_instr    <= '0;
            E_rs_data  <= '0;
            E_rt_data  <= '0;
            E_ext_imm  <= '0;
            E_exc_code <= '0;
            E_bd       <= D_bd;
            E_valid    <= 1'b0;
        end else begin
            E_pc       <= D_pc;
            E_instr    <= D_instr;
            E_rs_data  <= D_rs_data;
            E_rt_data  <= D_rt_data;
            E_ext_imm  <= D_ext_imm;
            E_exc_code <= D_exc_code;
            E_bd       <= D_bd;
            E_valid    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_d_e_reg.sv
// Bench for d_e_reg: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_d_e_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  exc;
        logic        bd;
    } d_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] imm;
        logic [4:0]  exc;
        logic        bd;
        logic        valid;
    } e_t;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic clk = 1'b0;
    logic reset, req, stall;
    d_t   din;
    e_t   obs;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    logic [31:0] E_pc, E_instr, E_rs_data, E_rt_data, E_ext_imm;
    logic [4:0]  E_exc_code;
    logic        E_bd, E_valid;

    always #5 clk = ~clk;

    d_e_reg dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .stall      (stall),
        .D_pc       (din.pc),
        .D_instr    (din.instr),
        .D_rs_data  (din.rs),
        .D_rt_data  (din.rt),
        .D_ext_imm  (din.imm),
        .D_exc_code (din.exc),
        .D_bd       (din.bd),
        .E_pc       (E_pc),
        .E_instr    (E_instr),
        .E_rs_data  (E_rs_data),
        .E_rt_data  (E_rt_data),
        .E_ext_imm  (E_ext_imm),
        .E_exc_code (E_exc_code),
        .E_bd       (E_bd),
        .E_valid    (E_valid)
    );

    assign obs = '{pc: E_pc, instr: E_instr, rs: E_rs_data, rt: E_rt_data,
                   imm: E_ext_imm, exc: E_exc_code, bd: E_bd, valid: E_valid};

    // What E should hold after an edge that sampled these controls and D fields.
    function automatic e_t model(input logic rq, input logic st, input d_t d);
        e_t e;
        e = '0;
        if (rq) begin
            e.pc = HANDLER_PC;
        end else if (st) begin
            e.pc = d.pc;
            e.bd = d.bd;
        end else begin
            e = '{pc: d.pc, instr: d.instr, rs: d.rs, rt: d.rt,
                  imm: d.imm, exc: d.exc, bd: d.bd, valid: 1'b1};
        end
        return e;
    endfunction

    function automatic d_t rand_d();
        d_t d;
        d.pc    = $urandom;
        d.instr = $urandom;
        d.rs    = $urandom;
        d.rt    = $urandom;
        d.imm   = $urandom;
        d.exc   = 5'($urandom_range(0, 31));
        d.bd    = 1'($urandom_range(0, 1));
        return d;
    endfunction

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        e_t exp;
        din   = rand_d();
        req   = 1'b0;
        stall = 1'b0;
        edge_step();
        exp = '0;
        exp.pc = RESET_PC;
        #2 reset = 1'b1;
        #1;
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL reset_async got %h want %h", obs, exp);
        end
        req   = 1'b1;
        stall = 1'b1;
        edge_step();
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL reset_holds got %h want %h", obs, exp);
        end
        req   = 1'b0;
        stall = 1'b0;
        #2 reset = 1'b0;
        din = rand_d();
        edge_step();
        cmp_cnt++;
        if (obs !== model(1'b0, 1'b0, din)) begin
            err_cnt++;
            $display("FAIL reset_release got %h want %h", obs, model(1'b0, 1'b0, din));
        end
    endtask

    task automatic test_normal();
        e_t exp;
        din = '{pc: 32'h3004, instr: 32'h3C01_1234, rs: 32'h11, rt: 32'h22,
                imm: 32'h1234_0000, exc: 5'd0, bd: 1'b0};
        exp = '{pc: 32'h3004, instr: 32'h3C01_1234, rs: 32'h11, rt: 32'h22,
                imm: 32'h1234_0000, exc: 5'd0, bd: 1'b0, valid: 1'b1};
        edge_step();
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL normal_load got %h want %h", obs, exp);
        end
    endtask

    task automatic test_stall();
        e_t exp;
        din = '{pc: 32'h3010, instr: 32'h2002_FFFF, rs: 32'hAAAA_5555, rt: 32'h1234_5678,
                imm: 32'hFFFF_FFFF, exc: 5'd10, bd: 1'b1};
        stall = 1'b1;
        exp = '0;
        exp.pc = 32'h3010;
        exp.bd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            cmp_cnt++;
            if (obs !== exp) begin
                err_cnt++;
                $display("FAIL stall_bubble_%0d got %h want %h", i, obs, exp);
            end
        end
        stall = 1'b0;
        exp = '{pc: 32'h3010, instr: 32'h2002_FFFF, rs: 32'hAAAA_5555, rt: 32'h1234_5678,
                imm: 32'hFFFF_FFFF, exc: 5'd10, bd: 1'b1, valid: 1'b1};
        edge_step();
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL stall_release got %h want %h", obs, exp);
        end
    endtask

    task automatic test_flush();
        e_t exp;
        exp = '0;
        exp.pc = HANDLER_PC;
        din = rand_d();
        din.pc  = 32'h3020;
        din.exc = 5'd4;
        din.bd  = 1'b1;
        req = 1'b1;
        edge_step();
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL flush got %h want %h", obs, exp);
        end
        stall = 1'b1;
        din = rand_d();
        edge_step();
        cmp_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL flush_over_stall got %h want %h", obs, exp);
        end
        req   = 1'b0;
        stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        e_t exp_q[$];
        e_t exp;
        for (int i = 0; i < 8; i++) begin
            din = rand_d();
            din.pc = 32'h3000 + 32'(i * 4);
            din.bd = 1'(i & 1);
            exp_q.push_back(model(1'b0, 1'b0, din));
            edge_step();
            exp = exp_q.pop_front();
            cmp_cnt++;
            if (obs !== exp) begin
                err_cnt++;
                $display("FAIL back_to_back_%0d got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        e_t exp;
        for (int i = 0; i < 300; i++) begin
            din   = rand_d();
            req   = ($urandom_range(0, 9) == 0);
            stall = ($urandom_range(0, 4) == 0);
            exp   = model(req, stall, din);
            edge_step();
            cmp_cnt++;
            if (obs !== exp) begin
                err_cnt++;
                $display("FAIL random_%0d req=%0b stall=%0b got %h want %h", i, req, stall, obs, exp);
            end
        end
        req   = 1'b0;
        stall = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        din   = '0;
        #12 reset = 1'b0;
        test_reset();
        test_normal();
        test_stall();
        test_flush();
        test_back_to_back();
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/d_e_reg.md
# d_e_reg

Decode-to-execute pipeline register of the five-stage MIPS CPU. Captures everything the D stage produces for one instruction: PC, instruction word, both register operands, the extended immediate, the pending exception code and the branch-delay flag. Presents them to the E stage one cycle later. Implements the pipeline's stall-bubble, exception-flush and reset behaviour, so E always sees either a real instruction or a clean nop carrying the correct PC/BD for CP0.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset
- HANDLER_PC, 32'h0000_4180, PC value loaded on exception flush
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears the register immediately
- req  in  1  exception/interrupt request from CP0; flushes the stage
- stall  in  1  hazard unit stall; inserts a bubble into E
- D_pc  in  32  PC of the instruction in D
- D_instr  in  32  instruction word in D
- D_rs_data  in  32  forwarded rs operand
- D_rt_data  in  32  forwarded rt operand
- D_ext_imm  in  32  extended immediate from the D-stage extender (zero-ext, sign-ext or lui form)
- D_exc_code  in  5  exception code detected in F/D (0 = none)
- D_bd  in  1  instruction sits in a branch delay slot
- E_pc, E_instr, E_rs_data, E_rt_data, E_ext_imm  out  32 each  registered copies
- E_exc_code  out  5  registered exception code
- E_bd  out  1  registered delay-slot flag
- E_valid  out  1  1 = E holds a real instruction, 0 = bubble/flush/reset

## Operation
- Update priority per rising edge, highest first: reset, req, stall, normal load.
- Reset (asynchronous, takes effect without a clock edge):
  - E_pc = RESET_PC.
  - All other outputs = 0, including E_valid = 0.
- req = 1 (flush):
  - E_pc = HANDLER_PC.
  - E_instr, E_rs_data, E_rt_data, E_ext_imm, E_exc_code, E_bd = 0; E_valid = 0.
  - Overrides stall in the same cycle.
- stall = 1, req = 0 (bubble):
  - E_instr, E_rs_data, E_rt_data, E_ext_imm, E_exc_code = 0; E_valid = 0.
  - E_pc = D_pc and E_bd = D_bd. The bubble carries the stalled instruction's PC/BD so CP0 computes the correct EPC if an interrupt lands on the bubble.
- Normal (stall = 0, req = 0): every E_* output = its D_* input; E_valid = 1.
- All fields are pure pass-through. No width conversion; D_ext_imm is stored verbatim.
- A bubble or flush encodes instr 0x0000_0000 (sll $0,$0,0). Downstream decodes it as a nop with no register write.
- D_exc_code is not interpreted here, only carried; a nonzero code on a bubble/flush is discarded.

## Timing
- Latency exactly 1 cycle, D to E.
- No internal state beyond the output registers; there is no state machine.
- Mode is selected by the sampled req/stall values at the edge.
- Reset deasserting mid-cycle: the first edge with reset = 0 performs a normal, stall or flush update from the inputs.
- Consecutive stalls: each cycle reloads D_pc/D_bd and zeros the rest. E_valid stays 0 for the whole stall.
- req and stall both high: flush wins, E_pc = HANDLER_PC.
- Reset asserted while req/stall high: reset wins immediately and asynchronously.

## Test plan
- Reset: assert reset mid-cycle, no clock edge -> E_pc = 0x0000_3000, all other outputs 0, E_valid = 0 immediately.
- Normal load: D_pc = 0x3004, D_instr = 0x3C01_1234 (lui), D_ext_imm = 0x1234_0000, D_rs_data = 0x11, D_rt_data = 0x22, D_exc_code = 0, D_bd = 0 -> after one edge all E_* match, E_valid = 1.
- Stall bubble: stall = 1, D_pc = 0x3010, D_bd = 1, D_instr = 0x2002_FFFF, D_ext_imm = 0xFFFF_FFFF -> E_pc = 0x3010, E_bd = 1, E_instr = 0, E_ext_imm = 0, E_valid = 0. Hold stall 3 cycles -> unchanged. Release -> instruction loads with E_valid = 1.
- Flush: req = 1 with D_exc_code = 5'd4, D_pc = 0x3020 -> E_pc = 0x4180, E_exc_code = 0, E_bd = 0, E_valid = 0.
- Simultaneous req and stall -> identical to the flush result; E_pc = 0x4180.
- Back-to-back loads of 0x3000..0x301C with alternating D_bd -> each appears on E exactly one cycle later with no drops or duplicates.
